// File: rtl/vga_timing_if.sv
// Raster outputs of vga_timing: coordinates, syncs, blanking and pixel/frame strobes.
// The timing generator drives the master modport; renderers and the connector take slave.
interface vga_timing_if;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       pix_tick;
  logic       frame_start;

  modport master (
    output hcount, vcount, hsync, vsync, video_on, pix_tick, frame_start
  );

  modport slave (
    input hcount, vcount, hsync, vsync, video_on, pix_tick, frame_start
  );
endinterface

// File: rtl/vga_timing.sv
// 640x480@60 VGA raster generator stepped by rising edges of t25MHz sampled on master.
// Define VGA_TIMING_PIPE_EN to delay hsync/vsync/video_on by one pixel behind the coordinates.
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic         master,
  input  logic         rst,
  input  logic         t25MHz,
  vga_timing_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic       t25_q;
  logic       advance;
  logic [9:0] h_next;
  logic [9:0] v_next;
  logic [9:0] dec_h;
  logic [9:0] dec_v;
  logic       hsync_d;
  logic       vsync_d;
  logic       video_on_d;

  // t25MHz is treated as data; only a fresh 0->1 step moves the raster.
  assign advance = t25MHz & ~t25_q;

  always_comb begin
    h_next = vga.hcount + 10'd1;
    v_next = vga.vcount;
    if (vga.hcount == H_LAST) begin
      h_next = '0;
      v_next = (vga.vcount == V_LAST) ? 10'd0 : vga.vcount + 10'd1;
    end
  end

  // Pipelined build decodes the position being left, so flags trail coordinates by a pixel.
`ifdef VGA_TIMING_PIPE_EN
  assign dec_h = vga.hcount;
  assign dec_v = vga.vcount;
`else
  assign dec_h = h_next;
  assign dec_v = v_next;
`endif

  assign hsync_d    = ~((dec_h >= HS_START) && (dec_h < HS_END));
  assign vsync_d    = ~((dec_v >= VS_START) && (dec_v < VS_END));
  assign video_on_d = (dec_h < H_VIS) && (dec_v < V_VIS);

  always_ff @(posedge master) begin
    if (rst) begin
      t25_q           <= 1'b0;
      vga.hcount      <= '0;
      vga.vcount      <= '0;
      vga.hsync       <= 1'b1;
      vga.vsync       <= 1'b1;
      vga.video_on    <= 1'b0;
      vga.pix_tick    <= 1'b0;
      vga.frame_start <= 1'b0;
    end else begin
      t25_q           <= t25MHz;
      vga.pix_tick    <= advance;
      vga.frame_start <= advance && (h_next == 10'd0) && (v_next == 10'd0);
      if (advance) begin
        vga.hcount   <= h_next;
        vga.vcount   <= v_next;
        vga.hsync    <= hsync_d;
        vga.vsync    <= vsync_d;
        vga.video_on <= video_on_d;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Randomised bench for vga_timing: a pixel-index model feeds a cycle-stamped scoreboard.
// Vertical timing is shortened so frame wrap and vsync fit in a short run.
module tb_vga_timing;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME_PIX = H_TOTAL * V_TOTAL;

  // {hcount, vcount, hsync, vsync, video_on, pix_tick, frame_start}
  localparam logic [24:0] RESET_OUTS = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  typedef struct {
    int          cyc;
    logic [24:0] outs;
  } exp_t;

  logic master = 1'b0;
  logic rst    = 1'b1;
  logic t25    = 1'b0;

  vga_timing_if vga();

  vga_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) dut (
    .master (master),
    .rst    (rst),
    .t25MHz (t25),
    .vga    (vga)
  );

  always #4 master = ~master;

  int   cyc = 0;
  logic rst_seen = 1'b1;
  always @(posedge master) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];
  int   model_pos  = 0;
  logic model_prev = 1'b0;
  int   exp_vid    = 0;
  int   obs_vid    = 0;
  int   obs_ticks  = 0;
  int   obs_frames = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // {hsync, vsync, video_on} straight from the VGA timing rules for linear pixel index pos.
  function automatic logic [2:0] flagsAt(input int pos);
    int h = pos % H_TOTAL;
    int v = pos / H_TOTAL;
    logic hs = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
    logic vs = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
    logic von = (h < H_ACTIVE) && (v < V_ACTIVE);
    return {hs, vs, von};
  endfunction

  task automatic pushAdvance();
    exp_t e;
    logic [2:0] f;
    int old = model_pos;
    model_pos = (model_pos + 1) % FRAME_PIX;
`ifdef VGA_TIMING_PIPE_EN
    f = flagsAt(old);
`else
    f = flagsAt(model_pos);
`endif
    e.cyc  = cyc + 1;
    e.outs = {10'(model_pos % H_TOTAL), 10'(model_pos / H_TOTAL), f, 1'b1, model_pos == 0};
    exp_vid += int'(f[0]);
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic t, input logic r);
    @(negedge master);
    t25 = t;
    rst = r;
    if (r) begin
      model_pos  = 0;
      model_prev = 1'b0;
    end else begin
      if (t && !model_prev) pushAdvance();
      model_prev = t;
    end
  endtask

  task automatic runPixel();
    repeat ($urandom_range(1, 2)) applyStimulus(1'b0, 1'b0);
    repeat ($urandom_range(1, 2)) applyStimulus(1'b1, 1'b0);
  endtask

  task automatic runTo(input int target);
    while (model_pos != target) runPixel();
    applyStimulus(1'b0, 1'b0);
  endtask

  // Scoreboard: each cycle either pops the advance due now or expects outputs to hold.
  logic [24:0] held = RESET_OUTS;
  int line_ticks = 0;
  int hs_low     = 0;
  always @(negedge master) begin : monitor
    logic [24:0] outs;
    logic [24:0] want;
    exp_t e;
    outs = {vga.hcount, vga.vcount, vga.hsync, vga.vsync, vga.video_on, vga.pix_tick, vga.frame_start};
    if (rst_seen) begin
      checkOutput("reset_state", 64'(outs), 64'(RESET_OUTS));
      held       = RESET_OUTS;
      line_ticks = 0;
      hs_low     = 0;
    end else begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e    = exp_q.pop_front();
        want = e.outs;
        held = {e.outs[24:2], 2'b00};
      end else begin
        want = held;
      end
      checkOutput("raster", 64'(outs), 64'(want));
      if (vga.pix_tick) begin
        obs_ticks++;
        obs_vid    += int'(vga.video_on);
        obs_frames += int'(vga.frame_start);
        if (vga.hcount == 10'd0) begin
          if (line_ticks == H_TOTAL) checkOutput("hsync_low_per_line", 64'(hs_low), 64'(H_SYNC));
          line_ticks = 0;
          hs_low     = 0;
        end
        line_ticks++;
        if (!vga.hsync) hs_low++;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: run did not complete, got cycle %0d, expected completion", cyc);
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int ticks_before;

    // Reset held while t25MHz keeps toggling: nothing may move.
    for (int i = 0; i < 10; i++) applyStimulus(1'(i % 2), 1'b1);
    checkOutput("reset_hold", 64'({vga.hcount, vga.vcount, vga.hsync, vga.vsync,
                                   vga.video_on, vga.pix_tick, vga.frame_start}), 64'(RESET_OUTS));
    checkOutput("reset_no_ticks", 64'(obs_ticks), 64'd0);

    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("first_advance", 64'({vga.hcount, vga.vcount}), 64'({10'd1, 10'd0}));

    // 2-high/2-low strobe: scoreboard cycle stamps pin the 4-cycle spacing.
    repeat (16) begin
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
    end

    applyStimulus(1'b0, 1'b0);
    ticks_before = obs_ticks;
    repeat (20) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("steady_high_ticks", 64'(obs_ticks - ticks_before), 64'd1);

    runTo(H_TOTAL - 1);
    checkOutput("line_end", 64'({vga.hcount, vga.vcount}), 64'({10'd799, 10'd0}));
    runTo(H_TOTAL);
    checkOutput("line_wrap", 64'({vga.hcount, vga.vcount}), 64'({10'd0, 10'd1}));

    runTo(0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("frame_wrap_pos", 64'({vga.hcount, vga.vcount, vga.video_on}), 64'({10'd0, 10'd0, 1'b1}));
    checkOutput("frame_start_count", 64'(obs_frames), 64'd1);
    checkOutput("video_on_tally", 64'(obs_vid), 64'(exp_vid));

    // Stop inside both sync pulses, then reset and release with the strobe high.
    runTo((V_ACTIVE + V_FP + 1) * H_TOTAL + 700);
    checkOutput("syncs_low_before_reset", 64'({vga.hcount, vga.vcount, vga.hsync, vga.vsync}),
                64'({10'd700, 10'(V_ACTIVE + V_FP + 1), 1'b0, 1'b0}));
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("midreset_state", 64'({vga.hcount, vga.vcount, vga.hsync, vga.vsync,
                                       vga.video_on, vga.pix_tick, vga.frame_start}), 64'(RESET_OUTS));
    applyStimulus(1'b0, 1'b0);
    checkOutput("release_advance", 64'({vga.hcount, vga.vcount, vga.pix_tick}), 64'({10'd1, 10'd0, 1'b1}));

    repeat (50) runPixel();
    repeat (3) applyStimulus(1'b0, 1'b0);
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    checkOutput("video_on_tally_end", 64'(obs_vid), 64'(exp_vid));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Generates 640x480 @ 60 Hz VGA raster timing for the minesweeper display. Sits directly downstream of `clock_dividers`: it runs on the `master` clock, uses that block's `t25MHz` output as a pixel-advance enable, and drives `hsync`/`vsync` to the connector plus pixel coordinates and a blanking flag to the board/cursor renderer. No second clock domain is introduced; `t25MHz` is sampled as data.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)

Ports:
- `master` in 1: system clock; all state updates on its rising edge
- `rst` in 1: synchronous, active-high reset
- `t25MHz` in 1: pixel-rate strobe/square wave from `clock_dividers`; a 0→1 transition sampled on `master` advances one pixel
- `hcount` out 10: current pixel column, 0..799
- `vcount` out 10: current line, 0..524
- `hsync` out 1: horizontal sync, active low
- `vsync` out 1: vertical sync, active low
- `video_on` out 1: high when the current position is inside the visible area
- `pix_tick` out 1: one-`master`-cycle pulse on each pixel advance
- `frame_start` out 1: one-`master`-cycle pulse on the advance to (0,0)

## Operation
- Edge detect: register `t25_q` holds the previous `t25MHz` sample. Advance when `t25MHz==1 && t25_q==0`. A steady-high `t25MHz` advances only once.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800), V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤1024.
- On each advance:
  - `hcount` increments.
  - At H_TOTAL-1 it wraps to 0 and `vcount` increments.
  - When `hcount==H_TOTAL-1` and `vcount==V_TOTAL-1`, both wrap to 0.
  - Without an advance, all counters and flags hold.
- Decode uses the new counter values, so flags always match `hcount`/`vcount` in the same cycle:
  - `hsync`=0 iff H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC (656..751).
  - `vsync`=0 iff V_ACTIVE+V_FP ≤ vcount < V_ACTIVE+V_FP+V_SYNC (490..491).
  - `video_on`=1 iff hcount<H_ACTIVE && vcount<V_ACTIVE.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Timing
- Reset values: `hcount`=0, `vcount`=0, `hsync`=1, `vsync`=1, `video_on`=0, `pix_tick`=0, `frame_start`=0, `t25_q`=0.
- `video_on` stays 0 after reset until the first advance. Reset overrides any simultaneous advance.
- Latency: the `master` edge that samples the 0→1 transition updates all outputs. They are visible in the following cycle, and `pix_tick` is high for exactly that cycle.
- Because `t25_q` resets to 0, `t25MHz` high on the first post-reset edge counts as an advance, moving the raster to (1,0).
- Frame wrap: the advance from (799,524) sets (0,0), `video_on`=1, `frame_start`=1 for one cycle. The next frame restarts at (0,0) after exactly 420000 advances.
- Reset mid-frame: on the next `master` edge the raster returns to the reset values, and syncs deassert (go high) even if they were low.
- With 100 MHz `master` and a 25 MHz `t25MHz`, `pix_tick` occurs every 4 cycles. The line period is 32 µs and the frame period is 16.8 ms.

## Configuration
- Macro: `VGA_TIMING_PIPE_EN`.
- Defined:
  - `hsync`, `vsync` and `video_on` pass through one extra register stage, enabled by the advance.
  - They lag `hcount`/`vcount` by exactly one pixel, which aligns them with a downstream renderer that registers pixel colour once from the coordinates.
  - That extra stage resets to 1/1/0.
- Undefined: flags are aligned with the coordinates, as described in Operation.
- The macro does not affect `pix_tick` or `frame_start` timing.

## Test plan
- Reset: hold `rst`=1 for 10 cycles with `t25MHz` toggling → all outputs equal their reset values and no `pix_tick`. Release → first advance gives `hcount`=1, `vcount`=0.
- Pixel rate: `master` period 8 ns, `t25MHz` 2-high/2-low → `pix_tick` exactly every 4 cycles. Hold `t25MHz`=1 for 20 cycles → exactly one advance.
- Line wrap: run to (799,0) then advance → (0,1). `hsync` is low for exactly hcount 656..751 (96 advances) on every line.
- Frame: run one full frame →
  - `vsync` low only for lines 490–491.
  - `frame_start` pulses exactly once, at (0,0).
  - `video_on` count = 307200 per frame.
- Mid-frame reset: assert `rst` at (700,491), with `hsync`=0 and `vsync`=0 → next cycle both are 1 and the raster is at (0,0). Released with `t25MHz` high → raster at (1,0).
- `VGA_TIMING_PIPE_EN` defined → `video_on` falls on the advance where `hcount` becomes 641 (not 640), and `hsync` falls at `hcount`=657.
